// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller slice.
// Contents:
//   - default address and data widths
//   - SDRAM command encodings {cs_n,ras_n,cas_n,we_n}
//   - the A10 precharge-all address pattern
//   - the one-hot arbiter state encoding
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PALL  = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // A10 high: driven while idle so a stray precharge would hit all banks.
    localparam logic [12:0] ADDR_A10_PALL = 13'h0400;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// Bundle of engine-side handshakes and SDRAM pin outputs around the arbiter.
// Modports:
//   slave  - the arbiter: consumes requests/commands, drives grants and pins
//   master - the engines/pad side: drives requests/commands, sees grants/pins
interface sdram_arbit_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              flag_init_end;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              flag_ref_end;
    logic [3:0]        ref_cmd;
    logic [ADDR_W-1:0] ref_addr;
    logic              aref_en;

    logic              wr_req;
    logic              flag_wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    logic              rd_req;
    logic              flag_rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;

    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [1:0]        sdram_bank;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  aref_req, flag_ref_end, ref_cmd, ref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output aref_req, flag_ref_end, ref_cmd, ref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data,
        output rd_req, flag_rd_end, rd_cmd, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_cmd_mux.sv
// Combinational routing of the owning engine's command/address/data onto
// the SDRAM pins, selected by the arbiter state register.
// Ports:
//   state                     current arbiter state
//   *_cmd / *_addr / wr_data  per-engine registered command, address, data
//   cmd, addr                 selected {cs_n,ras_n,cas_n,we_n} and address
//   dq_out, dq_oe             write data and pad output enable (WRITE only)
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  arb_state_e        state,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe
);
    localparam logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(ADDR_A10_PALL);

    // State-to-pin selection; idle and unreachable encodings drive NOP.
    always_comb begin
        cmd    = CMD_NOP;
        addr   = NOP_ADDR;
        dq_out = {DATA_W{1'b0}};
        dq_oe  = 1'b0;
        case (state)
            ST_INIT: begin
                cmd  = init_cmd;
                addr = init_addr;
            end
            ST_ARBIT: begin
                cmd  = CMD_NOP;
                addr = NOP_ADDR;
            end
            ST_AREF: begin
                cmd  = ref_cmd;
                addr = ref_addr;
            end
            ST_WRITE: begin
                cmd    = wr_cmd;
                addr   = wr_addr;
                dq_out = wr_data;
                dq_oe  = 1'b1;
            end
            ST_READ: begin
                cmd  = rd_cmd;
                addr = rd_addr;
            end
            default: begin
                cmd  = CMD_NOP;
                addr = NOP_ADDR;
            end
        endcase
    end
endmodule

// File: rtl/sdram_arbit.sv
// Central SDRAM command arbiter. Grants the bus to one of the init, refresh,
// write and read engines (fixed priority refresh > write > read), issues a
// one-cycle registered grant pulse on entry to the granted state, and routes
// the owner's command onto the pins through sdram_cmd_mux.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   sdram_arbit_if.slave: engine requests/commands/end flags in,
//         grants and SDRAM pins out
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sdram_arbit_if.slave  bus
);
    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              aref_en_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic [3:0]        cmd_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] dq_out_s;
    logic              dq_oe_s;

    // Next-state logic; end flags only matter to the engine that owns the bus.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (bus.flag_init_end) state_nxt_s = ST_ARBIT;
                else                   state_nxt_s = ST_INIT;
            end
            ST_ARBIT: begin
                if (bus.aref_req)    state_nxt_s = ST_AREF;
                else if (bus.wr_req) state_nxt_s = ST_WRITE;
                else if (bus.rd_req) state_nxt_s = ST_READ;
                else                 state_nxt_s = ST_ARBIT;
            end
            ST_AREF: begin
                if (bus.flag_ref_end) state_nxt_s = ST_ARBIT;
                else                  state_nxt_s = ST_AREF;
            end
            ST_WRITE: begin
                if (bus.flag_wr_end) state_nxt_s = ST_ARBIT;
                else                 state_nxt_s = ST_WRITE;
            end
            ST_READ: begin
                if (bus.flag_rd_end) state_nxt_s = ST_ARBIT;
                else                 state_nxt_s = ST_READ;
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_INIT;
        else     state_r <= state_nxt_s;
    end

    // Grant pulses: set only on the ARBIT->engine transition, so each lasts
    // exactly the first cycle of the owning state and never goes stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            aref_en_r <= 1'b0;
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
        end else begin
            aref_en_r <= (state_r == ST_ARBIT) && (state_nxt_s == ST_AREF);
            wr_en_r   <= (state_r == ST_ARBIT) && (state_nxt_s == ST_WRITE);
            rd_en_r   <= (state_r == ST_ARBIT) && (state_nxt_s == ST_READ);
        end
    end

    sdram_cmd_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_mux (
        .state     (state_r),
        .init_cmd  (bus.init_cmd),
        .init_addr (bus.init_addr),
        .ref_cmd   (bus.ref_cmd),
        .ref_addr  (bus.ref_addr),
        .wr_cmd    (bus.wr_cmd),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .rd_cmd    (bus.rd_cmd),
        .rd_addr   (bus.rd_addr),
        .cmd       (cmd_s),
        .addr      (addr_s),
        .dq_out    (dq_out_s),
        .dq_oe     (dq_oe_s)
    );

    assign bus.aref_en      = aref_en_r;
    assign bus.wr_en        = wr_en_r;
    assign bus.rd_en        = rd_en_r;
    assign bus.sdram_cke    = 1'b1;
    assign bus.sdram_bank   = 2'b00;
    assign bus.sdram_cs_n   = cmd_s[3];
    assign bus.sdram_ras_n  = cmd_s[2];
    assign bus.sdram_cas_n  = cmd_s[1];
    assign bus.sdram_we_n   = cmd_s[0];
    assign bus.sdram_addr   = addr_s;
    assign bus.sdram_dq_out = dq_out_s;
    assign bus.sdram_dq_oe  = dq_oe_s;
endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: a directed vector table walking the
// arbitration scenarios, a hand-written latency/pulse-width sequence, and a
// randomized phase compared against a bus-ownership reference model.
module tb_sdram_arbit;
    localparam int AW = 13;
    localparam int DW = 16;

    // Bus owner as seen by the reference model.
    localparam int O_INIT = 0;
    localparam int O_IDLE = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    int   m_owner = O_INIT;
    logic m_ga = 1'b0, m_gw = 1'b0, m_gr = 1'b0;

    sdram_arbit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arbit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, init_end, aref, ref_end, wr, wr_end, rd, rd_end;
        int   owner;
        logic ga, gw, gr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic ie, logic a, logic ae, logic w,
                                logic we, logic d, logic de, int o,
                                logic ga, logic gw, logic gr);
        vec_t v;
        v.rst = r; v.init_end = ie; v.aref = a; v.ref_end = ae;
        v.wr = w; v.wr_end = we; v.rd = d; v.rd_end = de;
        v.owner = o; v.ga = ga; v.gw = gw; v.gr = gr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: advance the ownership model on the edge, settle at negedge.
    task automatic tick();
        int prev;
        @(posedge clk);
        prev = m_owner;
        if (rst) m_owner = O_INIT;
        else if (m_owner == O_INIT) m_owner = bus.flag_init_end ? O_IDLE : O_INIT;
        else if (m_owner == O_IDLE) begin
            if (bus.aref_req)    m_owner = O_REF;
            else if (bus.wr_req) m_owner = O_WR;
            else if (bus.rd_req) m_owner = O_RD;
        end
        else if (m_owner == O_REF && bus.flag_ref_end) m_owner = O_IDLE;
        else if (m_owner == O_WR  && bus.flag_wr_end)  m_owner = O_IDLE;
        else if (m_owner == O_RD  && bus.flag_rd_end)  m_owner = O_IDLE;
        m_ga = (m_owner != prev) && (m_owner == O_REF);
        m_gw = (m_owner != prev) && (m_owner == O_WR);
        m_gr = (m_owner != prev) && (m_owner == O_RD);
        @(negedge clk);
    endtask

    // Compare every output against what the given owner implies.
    task automatic check_outputs(input int owner, input logic ga, input logic gw,
                                 input logic gr, input string tag);
        logic [3:0]    ecmd;
        logic [AW-1:0] eaddr;
        ecmd = 4'b0111; eaddr = 13'h0400;
        if (owner == O_INIT) begin ecmd = bus.init_cmd; eaddr = bus.init_addr; end
        if (owner == O_REF)  begin ecmd = bus.ref_cmd;  eaddr = bus.ref_addr;  end
        if (owner == O_WR)   begin ecmd = bus.wr_cmd;   eaddr = bus.wr_addr;   end
        if (owner == O_RD)   begin ecmd = bus.rd_cmd;   eaddr = bus.rd_addr;   end
        chk({tag, " grants"}, {29'd0, bus.aref_en, bus.wr_en, bus.rd_en}, {29'd0, ga, gw, gr});
        chk({tag, " cmd"}, {28'd0, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n},
            {28'd0, ecmd});
        chk({tag, " addr"}, {19'd0, bus.sdram_addr}, {19'd0, eaddr});
        chk({tag, " dq_oe"}, {31'd0, bus.sdram_dq_oe}, {31'd0, (owner == O_WR)});
        chk({tag, " dq_out"}, {16'd0, bus.sdram_dq_out},
            {16'd0, (owner == O_WR) ? bus.wr_data : 16'h0000});
        chk({tag, " cke_bank"}, {29'd0, bus.sdram_cke, bus.sdram_bank}, {29'd0, 1'b1, 2'b00});
    endtask

    task automatic drive_flags(input vec_t v);
        rst = v.rst;
        bus.flag_init_end = v.init_end;
        bus.aref_req = v.aref; bus.flag_ref_end = v.ref_end;
        bus.wr_req = v.wr;     bus.flag_wr_end = v.wr_end;
        bus.rd_req = v.rd;     bus.flag_rd_end = v.rd_end;
    endtask

    initial begin
        int  n;
        bit  seen;
        vec_t idle_v;

        bus.init_cmd = 4'h1; bus.init_addr = 13'h1111;
        bus.ref_cmd  = 4'h2; bus.ref_addr  = 13'h0222;
        bus.wr_cmd   = 4'h4; bus.wr_addr   = 13'h0333; bus.wr_data = 16'hBEEF;
        bus.rd_cmd   = 4'h5; bus.rd_addr   = 13'h0555;
        drive_flags(mk(1'b1,0,0,0,0,0,0,0, O_INIT,0,0,0));

        //          rst ie  a  ae  w  we  d  de  owner  ga gw gr
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_INIT, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, O_WR,   0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, O_WR,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, O_WR,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, O_REF,  1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, O_REF,  0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, O_WR,   0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, O_WR,   0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 0, O_REF,  1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, O_WR,   0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, O_RD,   0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, O_RD,   0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, O_INIT, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive_flags(tbl[i]);
            tick();
            check_outputs(tbl[i].owner, tbl[i].ga, tbl[i].gw, tbl[i].gr,
                          $sformatf("vec%0d", i));
        end

        // Request-to-grant latency, pulse width, and end-flag-to-regrant gap.
        idle_v = mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0);
        drive_flags(idle_v);
        bus.rd_req = 1'b1;
        n = 0; seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); n++;
            if (bus.rd_en) begin seen = 1; break; end
        end
        chk("rd_grant_latency", seen ? n : 99, 1);
        tick();
        chk("rd_grant_width", {31'd0, bus.rd_en}, 32'd0);
        bus.flag_rd_end = 1'b1;
        n = 0; seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); n++;
            bus.flag_rd_end = 1'b0;
            if (bus.rd_en) begin seen = 1; break; end
        end
        chk("rd_regrant_gap", seen ? n : 99, 2);
        bus.rd_req = 1'b0;
        bus.flag_rd_end = 1'b1;
        tick();
        bus.flag_rd_end = 1'b0;
        check_outputs(O_IDLE, 0, 0, 0, "hand_idle");

        // Randomized phase against the ownership model.
        for (int i = 0; i < 1500; i++) begin
            rst = (i == 0) || ($urandom_range(63) == 0);
            bus.flag_init_end = ($urandom_range(3) != 0);
            bus.aref_req      = ($urandom_range(3) == 0);
            bus.wr_req        = ($urandom_range(2) == 0);
            bus.rd_req        = ($urandom_range(2) == 0);
            bus.flag_ref_end  = ($urandom_range(3) == 0);
            bus.flag_wr_end   = ($urandom_range(3) == 0);
            bus.flag_rd_end   = ($urandom_range(3) == 0);
            bus.init_cmd  = 4'($urandom);  bus.init_addr = 13'($urandom);
            bus.ref_cmd   = 4'($urandom);  bus.ref_addr  = 13'($urandom);
            bus.wr_cmd    = 4'($urandom);  bus.wr_addr   = 13'($urandom);
            bus.wr_data   = 16'($urandom);
            bus.rd_cmd    = 4'($urandom);  bus.rd_addr   = 13'($urandom);
            tick();
            check_outputs(m_owner, m_ga, m_gw, m_gr, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
